fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction queue between the fetch stage and decode. Buffers {instr, nextPC}
//  pairs from fetch so that a decode-side stall does not lose fetched words.
//  Uses a valid/ready handshake on both sides and flushes on redirect
//  (branch, jump or exception).
//  Strict FIFO order. One-cycle latency from enqueue to out_valid. No combinational bypass.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  WIDTH   16  instruction and PC width in bits
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       fetch presents a word
//  in_ready    out  1       queue can accept this cycle
//  in_instr    in   WIDTH   fetched instruction
//  in_nextPC   in   WIDTH   PC+2 of the fetched instruction
//  out_valid   out  1       head entry is valid
//  out_ready   in   1       decode consumes head this cycle
//  out_instr   out  WIDTH   head instruction; 16'h0800 (NOP) when empty
//  out_nextPC  out  WIDTH   head PC+2; 0 when empty
//  flush       in   1       discard all entries (redirect)
//  count       out  log2(DEPTH)+1  entries held
//  halt_seen   out  1       HALT enqueued; 0 unless FQ_HALT_DETECT_EN
// BEHAVIOUR
//  - Reset (rst=1 at posedge): head=tail=0, count=0, halt_seen=0.
//    Consequently out_valid=0, out_instr=16'h0800, out_nextPC=0, in_ready=1.
//    Reset overrides flush, enq and deq.
//  - Storage: DEPTH x (2*WIDTH) register array.
//    head/tail are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  - in_ready  = (count != DEPTH) && !halt_seen. It is combinational from state
//    only and never depends on out_ready. A full queue does not accept a word
//    even when decode pops in the same cycle.
//  - enq = in_valid & in_ready & ~flush. On enq, write mem[tail] and advance tail.
//  - out_valid = (count != 0). out_instr and out_nextPC = mem[head] when valid,
//    otherwise the NOP/0 values.
//  - deq = out_valid & out_ready & ~flush. On deq, advance head.
//  - count updates: +1 on enq only; -1 on deq only; unchanged on both;
//    unchanged on neither.
//  - flush (priority over enq and deq): next cycle head=tail=0, count=0,
//    halt_seen=0. A word offered in the flush cycle is dropped.
//    in_ready is 1 in the cycle after the flush.
//  - Outputs are driven solely from registered state (Moore). No state machine
//    beyond pointers, count and halt_seen.
//  - X-safety: out_* must never expose stale mem contents while count==0.
// CONFIGURATION
//  FQ_HALT_DETECT_EN defined:
//    - An enq with in_instr[15:11]==5'b00000 (HALT) sets halt_seen next cycle.
//    - in_ready then holds 0 until flush or rst.
//    - The HALT entry itself is queued and drains normally.
//    - Entries queued before the HALT are unaffected.
//  FQ_HALT_DETECT_EN undefined:
//    - halt_seen is tied 0.
//    - HALT words are queued like any other instruction.
// TESTING
//  1 Reset:
//    - Assert rst for 2 cycles with in_valid=1.
//    - Expect count=0, out_valid=0, out_instr=16'h0800, in_ready=1.
//  2 Fill:
//    - out_ready=0; enqueue instr 16'h4001..16'h4004.
//    - Expect count=4 and in_ready=0.
//    - Offer a 5th word 16'h4005 with in_valid=1; expect it rejected and count stays 4.
//  3 Simultaneous enq/deq:
//    - With count=2, set in_valid=1 and out_ready=1 for 3 cycles.
//    - Expect count=2 throughout and output order matching input order.
//  4 Wrap-around:
//    - Push 10 words with nextPC 0x0002..0x0014 while popping at random.
//    - Expect all 10 delivered in order, no duplicates or losses.
//  5 Flush:
//    - With count=3, assert flush with in_valid=1, out_ready=1.
//    - Next cycle expect count=0, out_valid=0, and no deq observed.
//    - The offered word is dropped.
//  6 Halt (macro on):
//    - Enqueue 16'h0000 then 16'h4006.
//    - Expect halt_seen=1 and in_ready=0; 16'h4006 is not accepted.
//    - The HALT word drains via out_*.
//    - flush clears halt_seen.
//    - With the macro off, both words are queued and halt_seen=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: strict FIFO of {instr, nextPC} pairs
// with valid/ready on both sides and flush on redirect. Optional HALT detection: FQ_HALT_DETECT_EN.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_instr,
   input  logic [WIDTH-1:0]         in_nextPC,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_instr,
   output logic [WIDTH-1:0]         out_nextPC,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     halt_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(16'h0800);
   localparam logic [AW:0]      FULL      = (AW + 1)'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] instr;
      logic [WIDTH-1:0] next_pc;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        head_e;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          halt_q;
   logic          enq, deq;

   // Handshake qualifiers; flush suppresses both sides in its cycle.
   assign in_ready  = (count_q != FULL) && !halt_q;
   assign out_valid = (count_q != '0);
   assign enq       = in_valid && in_ready && !flush;
   assign deq       = out_valid && out_ready && !flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + AW'(1);
         if (deq) head_d = head_q + AW'(1);
         if (enq && !deq)      count_d = count_q + 1'b1;
         else if (deq && !enq) count_d = count_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values computed by the always_comb above.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; count gates every read,
   // so its power-up contents are never visible.
   always_ff @(posedge clk) begin
      if (!rst && enq) mem_q[tail_q] <= '{instr: in_instr, next_pc: in_nextPC};
   end

`ifdef FQ_HALT_DETECT_EN
   logic halt_d;

   always_comb begin
      halt_d = halt_q;
      if (flush)                                       halt_d = 1'b0;
      else if (enq && in_instr[WIDTH-1 -: 5] == 5'b0)  halt_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) halt_q <= 1'b0;
      else     halt_q <= halt_d;
   end
`else
   assign halt_q = 1'b0;
`endif

   assign head_e     = mem_q[head_q];
   assign out_instr  = out_valid ? head_e.instr   : NOP_INSTR;
   assign out_nextPC = out_valid ? head_e.next_pc : '0;
   assign count      = count_q;
   assign halt_seen  = halt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a random soak,
// all checked against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 16;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, out_valid, out_ready, flush, halt_seen;
   logic [WIDTH-1:0]  in_instr, in_nextPC, out_instr, out_nextPC;
   logic [2:0]        count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mq [$];   // reference queue of {instr, nextPC}
   logic [31:0] obs [$];  // words observed leaving the DUT
   bit          halt_m;

   fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_nextPC(in_nextPC),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_nextPC(out_nextPC),
      .flush(flush), .count(count), .halt_seen(halt_seen)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_ready();
      return (mq.size() < DEPTH) && !halt_m;
   endfunction

   task automatic model_step();
      bit acc, pop;
      if (rst || flush) begin
         mq.delete();
         halt_m = 1'b0;
      end else begin
         acc = in_valid && model_ready();
         pop = (mq.size() != 0) && out_ready;
         if (pop) void'(mq.pop_front());
         if (acc) begin
            mq.push_back({in_instr, in_nextPC});
`ifdef FQ_HALT_DETECT_EN
            if (in_instr[15:11] == 5'b0) halt_m = 1'b1;
`endif
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] head;
      head = (mq.size() != 0) ? mq[0] : {16'h0800, 16'h0000};
      check({tag, ".count"},     count,      mq.size());
      check({tag, ".out_valid"}, out_valid,  mq.size() != 0);
      check({tag, ".out_instr"}, out_instr,  head[31:16]);
      check({tag, ".out_pc"},    out_nextPC, head[15:0]);
      check({tag, ".in_ready"},  in_ready,   model_ready());
      check({tag, ".halt"},      halt_seen,  halt_m);
   endtask

   // One clock: record any handshake leaving the DUT, advance model, check at negedge.
   task automatic cycle(input string tag);
      if (out_valid === 1'b1 && out_ready && !flush && !rst)
         obs.push_back({out_instr, out_nextPC});
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, budget;
      halt_m    = 1'b0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_instr  = 16'h4abc;
      in_nextPC = 16'h0002;
      @(negedge clk);

      // Reset with in_valid held high
      cycle("rst0");
      cycle("rst1");
      check("rst.count", count, 0);
      check("rst.out_valid", out_valid, 0);
      check("rst.out_instr", out_instr, 16'h0800);
      check("rst.in_ready", in_ready, 1);
      rst = 1'b0;

      // Fill to DEPTH, then offer one more
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid  = 1'b1;
         in_instr  = 16'h4000 + 16'(i);
         in_nextPC = 16'(2 * i);
         cycle("fill");
      end
      check("fill.count", count, 4);
      check("fill.in_ready", in_ready, 0);
      in_instr  = 16'h4005;
      in_nextPC = 16'h000a;
      cycle("fill5");
      check("fill5.count", count, 4);
      check("fill5.head", out_instr, 16'h4001);

      // Drain to two, then enqueue and dequeue together for three cycles
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle("pop");
      cycle("pop");
      check("simul.start", count, 2);
      obs.delete();
      for (int k = 0; k < 3; k++) begin
         in_valid  = 1'b1;
         in_instr  = 16'h4010 + 16'(k);
         in_nextPC = 16'h0100 + 16'(2 * k);
         cycle("simul");
         check("simul.count", count, 2);
      end
      check("simul.n", obs.size(), 3);
      if (obs.size() == 3) begin
         check("simul.o0", obs[0][31:16], 16'h4003);
         check("simul.o1", obs[1][31:16], 16'h4004);
         check("simul.o2", obs[2][31:16], 16'h4010);
      end
      in_valid = 1'b0;
      budget = 0;
      while (count !== 3'd0 && budget < 20) begin
         cycle("drain");
         budget++;
      end
      check("drain.empty", count, 0);

      // Wrap-around: 10 words with random popping
      obs.delete();
      sent   = 0;
      budget = 0;
      while (obs.size() < 10 && budget < 400) begin
         in_valid  = (sent < 10);
         in_instr  = 16'h4100 + 16'(sent);
         in_nextPC = 16'(2 * (sent + 1));
         out_ready = (sent >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
         if (in_valid && model_ready()) sent++;
         cycle("wrap");
         budget++;
      end
      check("wrap.n", obs.size(), 10);
      for (int i = 0; i < obs.size() && i < 10; i++) begin
         check("wrap.instr", obs[i][31:16], 16'h4100 + 16'(i));
         check("wrap.pc",    obs[i][15:0],  16'(2 * (i + 1)));
      end
      in_valid = 1'b0;

      // Flush with a word offered and decode ready
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_instr = 16'h4200 + 16'(i);
         cycle("pref");
      end
      check("flush.pre", count, 3);
      obs.delete();
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 16'h4299;
      out_ready = 1'b1;
      cycle("flush");
      flush = 1'b0;
      check("flush.count", count, 0);
      check("flush.out_valid", out_valid, 0);
      check("flush.in_ready", in_ready, 1);
      check("flush.no_deq", obs.size(), 0);
      in_valid = 1'b0;
      cycle("postflush");
      check("flush.dropped", count, 0);

      // HALT followed by a normal word
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 16'h0000;
      in_nextPC = 16'h0030;
      cycle("halt0");
      in_instr  = 16'h4006;
      in_nextPC = 16'h0032;
      cycle("halt1");
      in_valid = 1'b0;
      obs.delete();
`ifdef FQ_HALT_DETECT_EN
      check("halt.seen", halt_seen, 1);
      check("halt.in_ready", in_ready, 0);
      check("halt.count", count, 1);
      out_ready = 1'b1;
      cycle("haltdrain");
      check("halt.drained", obs.size(), 1);
      if (obs.size() == 1) check("halt.word", obs[0][31:16], 16'h0000);
      check("halt.still", halt_seen, 1);
      flush = 1'b1;
      cycle("haltflush");
      flush = 1'b0;
      check("halt.cleared", halt_seen, 0);
      check("halt.ready", in_ready, 1);
`else
      check("halt.seen", halt_seen, 0);
      check("halt.count", count, 2);
      out_ready = 1'b1;
      cycle("haltdrain0");
      cycle("haltdrain1");
      check("halt.n", obs.size(), 2);
      if (obs.size() == 2) begin
         check("halt.w0", obs[0][31:16], 16'h0000);
         check("halt.w1", obs[1][31:16], 16'h4006);
      end
`endif

      // Random soak
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         flush     = ($urandom_range(0, 29) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 2) != 0);
         in_instr  = ($urandom_range(0, 15) == 0) ? 16'(16'($urandom) & 16'h07ff)
                                                  : 16'($urandom) | 16'h0800;
         in_nextPC = 16'($urandom);
         cycle("soak");
      end
      rst   = 1'b0;
      flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
